// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, 3-sample majority vote per bit,
// framing-error detection and a one-deep holding register with overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Rd,
  output logic       o_Rx_Valid,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Overrun,
  output logic       o_Rx_Active
);
  localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] MID  = 10'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, CLEANUP} state_t;

  state_t      state, next_state;
  logic        rx_meta, rx_s;
  logic [9:0]  r_Clock_Count;
  logic [2:0]  bit_idx;
  logic [2:0]  samp;
  logic [7:0]  shift;
  logic        maj, done, in_frame, commit, bad_stop;

  assign maj      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign done     = (r_Clock_Count == LAST);
  assign in_frame = (state == START) || (state == DATA) || (state == STOP);
  assign commit   = (state == STOP) && done && maj;
  assign bad_stop = (state == STOP) && done && !maj;

  // Active only once the start bit is confirmed, so a rejected glitch never shows.
  assign o_Rx_Active = (state == DATA) || (state == STOP);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (done) next_state = maj ? IDLE : DATA;
      DATA:    if (done && bit_idx == 3'd7) next_state = STOP;
      STOP:    if (done) next_state = maj ? CLEANUP : BREAK;
      BREAK:   if (rx_s) next_state = IDLE;
      CLEANUP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      r_Clock_Count  <= '0;
      bit_idx        <= '0;
      samp           <= '0;
      shift          <= '0;
      o_Rx_Valid     <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Overrun   <= 1'b0;
    end else begin
      rx_meta        <= i_Rx_Serial;
      rx_s           <= rx_meta;
      o_Rx_Frame_Err <= bad_stop;

      if (in_frame) r_Clock_Count <= done ? 10'd0 : r_Clock_Count + 10'd1;
      else          r_Clock_Count <= '0;

      if (in_frame) begin
        if (r_Clock_Count == MID - 10'd1) samp[0] <= rx_s;
        if (r_Clock_Count == MID)         samp[1] <= rx_s;
        if (r_Clock_Count == MID + 10'd1) samp[2] <= rx_s;
      end

      if (state == DATA) begin
        if (done) begin
          shift[bit_idx] <= maj;
          bit_idx        <= bit_idx + 3'd1;
        end
      end else begin
        bit_idx <= '0;
      end

      // A read coinciding with a commit consumes the old byte, so no overrun.
      if (commit) begin
        o_Rx_Valid <= 1'b1;
        o_Rx_Byte  <= shift;
        if (o_Rx_Valid && !i_Rx_Rd) o_Rx_Overrun <= 1'b1;
      end else if (i_Rx_Rd && o_Rx_Valid) begin
        o_Rx_Valid   <= 1'b0;
        o_Rx_Overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n, i_Rx_Serial, i_Rx_Rd;
  logic       o_Rx_Valid, o_Rx_Frame_Err, o_Rx_Overrun, o_Rx_Active;
  logic [7:0] o_Rx_Byte;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Rx_Serial(i_Rx_Serial), .i_Rx_Rd(i_Rx_Rd),
    .o_Rx_Valid(o_Rx_Valid), .o_Rx_Byte(o_Rx_Byte), .o_Rx_Frame_Err(o_Rx_Frame_Err),
    .o_Rx_Overrun(o_Rx_Overrun), .o_Rx_Active(o_Rx_Active)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {logic [7:0] data; logic ferr;} exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0, cyc = 0, ferr_cnt = 0;
  bit act_seen = 0, prev_act = 0, abort_ok = 0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every end of frame (Active falling) pops one expected result.
  always @(negedge i_Clock) begin
    exp_t e;
    if (o_Rx_Active) act_seen = 1;
    if (o_Rx_Frame_Err) ferr_cnt++;
    if (prev_act && !o_Rx_Active) begin
      if (abort_ok) abort_ok = 0;
      else begin
        chk("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("frame_err", o_Rx_Frame_Err, e.ferr);
          if (!e.ferr) begin
            chk("rx_byte", o_Rx_Byte, e.data);
            chk("rx_valid", o_Rx_Valid, 1);
          end
        end
      end
    end
    prev_act = o_Rx_Active;
  end

  // Drives one frame, one clock per step; optional 1-clk high pulse / sync reset.
  task automatic send(input logic [7:0] b, input logic stop, input int pulse_bit,
                      input int rst_bit, input bit expect_out);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (expect_out) sb.push_back('{data: b, ferr: !stop});
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++) begin
        i_Rx_Serial = fr[i] ^ (i == pulse_bit && j == 8);
        i_Rst_n     = !(i == rst_bit && j == 4);
        @(posedge i_Clock); #1;
        if (!i_Rst_n) begin
          chk("rst_valid", o_Rx_Valid, 0);
          chk("rst_byte", o_Rx_Byte, 0);
          chk("rst_ferr", o_Rx_Frame_Err, 0);
          chk("rst_ovr", o_Rx_Overrun, 0);
          chk("rst_active", o_Rx_Active, 0);
        end
      end
    i_Rx_Serial = 1'b1;
    i_Rst_n     = 1'b1;
  endtask

  task automatic rd_pulse();
    i_Rx_Rd = 1'b1;
    @(posedge i_Clock); #1;
    i_Rx_Rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  initial begin
    int t0, lat;
    i_Rst_n = 1'b0; i_Rx_Serial = 1'b1; i_Rx_Rd = 1'b0;
    idle(3);
    chk("init_valid", o_Rx_Valid, 0);
    chk("init_byte", o_Rx_Byte, 0);
    chk("init_ferr", o_Rx_Frame_Err, 0);
    chk("init_ovr", o_Rx_Overrun, 0);
    chk("init_active", o_Rx_Active, 0);
    i_Rst_n = 1'b1;
    idle(5);

    // Pin driven just after edge k is first sampled at k+1; 2 sync flops then 10 bit periods.
    t0 = cyc; lat = -1;
    fork
      send(8'hA5, 1'b1, -1, -1, 1);
      for (int i = 0; i < 400 && lat < 0; i++) begin
        @(negedge i_Clock);
        if (o_Rx_Valid) lat = cyc - t0;
      end
    join
    chk("latency", lat, 10 * CPB + 3);
    chk("a5_ovr", o_Rx_Overrun, 0);
    rd_pulse();
    chk("a5_read_valid", o_Rx_Valid, 0);

    act_seen = 0;
    i_Rx_Serial = 1'b0;
    idle(4);
    i_Rx_Serial = 1'b1;
    idle(40);
    chk("glitch_active", act_seen, 0);
    chk("glitch_valid", o_Rx_Valid, 0);

    send(8'h3C, 1'b0, -1, -1, 1);
    idle(10);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_valid", o_Rx_Valid, 0);
    send(8'h81, 1'b1, -1, -1, 1);
    idle(10);
    chk("81_byte", o_Rx_Byte, 8'h81);
    rd_pulse();

    send(8'h11, 1'b1, -1, -1, 1);
    send(8'h22, 1'b1, -1, -1, 1);
    idle(10);
    chk("ovr_byte", o_Rx_Byte, 8'h22);
    chk("ovr_valid", o_Rx_Valid, 1);
    chk("ovr_flag", o_Rx_Overrun, 1);
    rd_pulse();
    chk("ovr_rd_valid", o_Rx_Valid, 0);
    chk("ovr_rd_flag", o_Rx_Overrun, 0);
    rd_pulse();
    chk("rd_empty_valid", o_Rx_Valid, 0);

    send(8'h00, 1'b1, 4, -1, 1);
    idle(10);
    chk("pulse_byte", o_Rx_Byte, 8'h00);
    chk("pulse_valid", o_Rx_Valid, 1);

    abort_ok = 1;
    send(8'hFF, 1'b1, -1, 5, 0);
    idle(20);
    chk("abort_valid", o_Rx_Valid, 0);
    send(8'h5A, 1'b1, -1, -1, 1);
    idle(10);
    chk("5a_byte", o_Rx_Byte, 8'h5A);
    chk("5a_ovr", o_Rx_Overrun, 0);

    chk("sb_drained", sb.size(), 0);
    chk("ferr_total", ferr_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
